// File: rtl/burst_rd_pkg.sv
// Shared types and helpers for the burst read master: one-hot FSM encoding and
// the window-limited burst length calculation.
package burst_rd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_WAIT  = 4'b0010,
      ST_ISSUE = 4'b0100,
      ST_DRAIN = 4'b1000
   } state_e;

   // Largest burst that neither exceeds the words left nor crosses a
   // max_burst-word aligned window; max_burst must be a power of two.
   function automatic logic [31:0] min_burst(input logic [31:0] remaining,
                                             input logic [31:0] addr_word,
                                             input logic [31:0] max_burst);
      logic [31:0] room;
      room = max_burst - (addr_word & (max_burst - 32'd1));
      return (remaining < room) ? remaining : room;
   endfunction

endpackage

// File: rtl/burst_read_master_if.sv
// Avalon-MM burst read bus between the read master and the memory slave.
interface burst_read_master_if #(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int BURST_WIDTH   = 4
);
   logic [ADDRESS_WIDTH-1:0] master_address;
   logic                     master_read;
   logic [BURST_WIDTH-1:0]   master_burstcount;
   logic [DATA_WIDTH/8-1:0]  master_byteenable;
   logic                     master_waitrequest;
   logic                     master_readdatavalid;
   logic [DATA_WIDTH-1:0]    master_readdata;

   modport master (
      output master_address, master_read, master_burstcount, master_byteenable,
      input  master_waitrequest, master_readdatavalid, master_readdata
   );

   modport slave (
      input  master_address, master_read, master_burstcount, master_byteenable,
      output master_waitrequest, master_readdatavalid, master_readdata
   );
endinterface

// File: rtl/burst_rd_fifo.sv
// Show-ahead synchronous FIFO buffering returned read data; the head word is
// visible on rdata whenever the FIFO is not empty.
module burst_rd_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_AW    = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [FIFO_AW:0]      count,
   output logic                  full,
   output logic                  empty
);
   localparam int DEPTH = 1 << FIFO_AW;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [FIFO_AW:0]      count_q, count_d;
   logic                  do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
   assign count   = count_q;
   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so push-at-full with pop is legal.
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (FIFO_AW+1)'(1);
         2'b01:   count_d = count_q - (FIFO_AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/burst_read_master.sv
// Avalon-MM burst read master: splits a block read into window-aligned bursts,
// issues each only when the FIFO can absorb it, and streams the data out.
module burst_read_master
   import burst_rd_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 32,
   parameter int DATA_WIDTH    = 32,
   parameter int LENGTH_WIDTH  = 16,
   parameter int MAX_BURST     = 8,
   parameter int BURST_WIDTH   = 4,
   parameter int FIFO_DEPTH    = 32
) (
   input  logic                     clk,
   input  logic                     reset_n,
   burst_read_master_if.master      avm,
   input  logic                     ctrl_start,
   input  logic [ADDRESS_WIDTH-1:0] ctrl_baseaddress,
   input  logic [LENGTH_WIDTH-1:0]  ctrl_length,
   output logic                     ctrl_busy,
   output logic                     ctrl_done,
   output logic [DATA_WIDTH-1:0]    st_data,
   output logic                     st_valid,
   input  logic                     st_ready
);
   localparam int BYTE_ENABLE_WIDTH = DATA_WIDTH / 8;
   localparam int BE_SHIFT          = $clog2(BYTE_ENABLE_WIDTH);
   localparam int FIFO_AW           = $clog2(FIFO_DEPTH);
   localparam int OW                = LENGTH_WIDTH + 1;

   state_e                   state_q, state_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
   logic [OW-1:0]            outstanding_q, outstanding_d;
   logic [BURST_WIDTH-1:0]   burst_q, burst_d;
   logic                     read_q, read_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;

   logic [FIFO_AW:0]         fifo_count;
   logic                     fifo_full, fifo_empty;
   logic                     rdv_accept, req_accept, credit_ok;
   logic [31:0]              next_burst, credit_free;

   // Returns with nothing outstanding are leftovers from before a reset.
   assign rdv_accept  = avm.master_readdatavalid && (outstanding_q != '0);
   assign req_accept  = read_q && !avm.master_waitrequest;
   assign next_burst  = min_burst(32'(remaining_q), 32'(addr_q >> BE_SHIFT), 32'(MAX_BURST));
   assign credit_free = 32'(FIFO_DEPTH) - (32'(fifo_count) + 32'(outstanding_q));
   assign credit_ok   = !fifo_full && (credit_free >= next_burst);

   assign avm.master_address    = addr_q;
   assign avm.master_read       = read_q;
   assign avm.master_burstcount = burst_q;
   assign avm.master_byteenable = '1;
   assign ctrl_busy             = busy_q;
   assign ctrl_done             = done_q;
   assign st_valid              = !fifo_empty;

   always_comb begin
      outstanding_d = outstanding_q;
      if (req_accept) outstanding_d = outstanding_d + OW'(burst_q);
      if (rdv_accept) outstanding_d = outstanding_d - OW'(1);
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      burst_d     = burst_q;
      read_d      = read_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_start) begin
               addr_d      = ctrl_baseaddress;
               remaining_d = ctrl_length;
               busy_d      = 1'b1;
               state_d     = (ctrl_length == '0) ? ST_DRAIN : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (remaining_q == '0) begin
               state_d = ST_DRAIN;
            end else if (credit_ok) begin
               read_d  = 1'b1;
               burst_d = BURST_WIDTH'(next_burst);
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (req_accept) begin
               read_d      = 1'b0;
               addr_d      = addr_q + (ADDRESS_WIDTH'(burst_q) << BE_SHIFT);
               remaining_d = remaining_q - LENGTH_WIDTH'(burst_q);
               state_d     = ST_WAIT;
            end
         end
         ST_DRAIN: begin
            if (outstanding_q == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         outstanding_q <= '0;
         burst_q       <= '0;
         read_q        <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         outstanding_q <= outstanding_d;
         burst_q       <= burst_d;
         read_q        <= read_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   burst_rd_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_AW    (FIFO_AW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (reset_n),
      .push  (rdv_accept),
      .pop   (st_valid && st_ready),
      .wdata (avm.master_readdata),
      .rdata (st_data),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_burst_read_master.sv
// Directed bench for burst_read_master: zero/stall-capable slave model on the
// negative edge, address-keyed data so stream order is checked independently.
module tb_burst_read_master;
   localparam int AW = 32, DW = 32, LW = 16, MB = 8, BW = 4, FD = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   burst_read_master_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) avm ();

   logic          ctrl_start = 1'b0;
   logic [AW-1:0] ctrl_baseaddress = '0;
   logic [LW-1:0] ctrl_length = '0;
   logic          ctrl_busy, ctrl_done;
   logic [DW-1:0] st_data;
   logic          st_valid;
   logic          st_ready = 1'b0;

   burst_read_master #(
      .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .LENGTH_WIDTH(LW),
      .MAX_BURST(MB), .BURST_WIDTH(BW), .FIFO_DEPTH(FD)
   ) dut (
      .clk              (clk),
      .reset_n          (rst_n),
      .avm              (avm),
      .ctrl_start       (ctrl_start),
      .ctrl_baseaddress (ctrl_baseaddress),
      .ctrl_length      (ctrl_length),
      .ctrl_busy        (ctrl_busy),
      .ctrl_done        (ctrl_done),
      .st_data          (st_data),
      .st_valid         (st_valid),
      .st_ready         (st_ready)
   );

   typedef struct { logic [31:0] addr; logic stale; } word_t;
   typedef struct { logic [31:0] addr; int cnt; int cyc; } req_t;

   word_t pend[$];
   req_t  reqs[$];

   int n_chk = 0, n_pass = 0;
   int wait_left = 0, ret_budget = -1, pop_budget = -1;
   int occ = 0, pops = 0, rets = 0, stale_rets = 0, done_cnt = 0;
   int cyc = 0, last_rdv_cyc = 0, done_cyc = 0;
   bit saw_read = 0, cons_ready = 0;
   logic [31:0] exp_addr = '0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   task automatic clr();
      reqs.delete();
      done_cnt = 0; pops = 0; rets = 0; stale_rets = 0; saw_read = 0;
   endtask

   task automatic start(input logic [31:0] base, input logic [15:0] len);
      ctrl_baseaddress = base;
      ctrl_length      = len;
      exp_addr         = base;
      ctrl_start       = 1'b1;
      step(1);
      ctrl_start       = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while (done_cnt == 0 && n < max) begin step(1); n++; end
      chk("done_seen", 64'(done_cnt != 0), 64'd1);
   endtask

   task automatic chk_req(input string tag, input int idx, input logic [31:0] a, input int c);
      if (idx < reqs.size()) begin
         chk({tag, "_addr"}, 64'(reqs[idx].addr), 64'(a));
         chk({tag, "_cnt"}, 64'(reqs[idx].cnt), 64'(c));
      end else begin
         chk({tag, "_present"}, 64'(reqs.size()), 64'(idx + 1));
      end
   endtask

   // Slave + consumer model: everything here is decided on the falling edge
   // and sampled by the DUT on the following rising edge.
   initial begin
      word_t w;
      avm.master_waitrequest   = 1'b0;
      avm.master_readdatavalid = 1'b0;
      avm.master_readdata      = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            avm.master_readdatavalid = 1'b0;
            avm.master_waitrequest   = 1'b0;
            st_ready                 = 1'b0;
         end else begin
            chk("st_valid", 64'(st_valid), 64'(occ != 0));
            if (ctrl_done) begin done_cnt++; done_cyc = cyc; end
            if (avm.master_read) saw_read = 1;

            st_ready = cons_ready && (pop_budget != 0);
            if (st_valid && st_ready) begin
               chk("st_data", 64'(st_data), 64'(exp_addr ^ 32'h5A5A5A5A));
               exp_addr += 32'd4;
               occ--; pops++;
               if (pop_budget > 0) pop_budget--;
            end

            avm.master_readdatavalid = 1'b0;
            if (pend.size() != 0 && ret_budget != 0) begin
               w = pend.pop_front();
               avm.master_readdatavalid = 1'b1;
               avm.master_readdata      = w.addr ^ 32'h5A5A5A5A;
               last_rdv_cyc = cyc;
               if (ret_budget > 0) ret_budget--;
               if (w.stale) stale_rets++;
               else begin
                  rets++; occ++;
                  chk("fifo_room", 64'(occ <= FD), 64'd1);
               end
            end

            avm.master_waitrequest = 1'b0;
            if (avm.master_read) begin
               if (wait_left > 0) begin
                  avm.master_waitrequest = 1'b1;
                  wait_left--;
               end else begin
                  reqs.push_back('{avm.master_address, int'(avm.master_burstcount), cyc});
                  for (int i = 0; i < int'(avm.master_burstcount); i++)
                     pend.push_back('{avm.master_address + 32'(4 * i), 1'b0});
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // reset values
      #1;
      chk("rst_read",  64'(avm.master_read), 64'd0);
      chk("rst_addr",  64'(avm.master_address), 64'd0);
      chk("rst_burst", 64'(avm.master_burstcount), 64'd0);
      chk("rst_be",    64'(avm.master_byteenable), 64'hF);
      chk("rst_busy",  64'(ctrl_busy), 64'd0);
      chk("rst_done",  64'(ctrl_done), 64'd0);
      chk("rst_valid", 64'(st_valid), 64'd0);
      chk("rst_data",  64'(st_data), 64'd0);
      step(3);
      rst_n = 1'b1;
      step(2);

      // aligned 20 words: 8 + 8 + 4
      clr(); cons_ready = 1;
      start(32'h39000000, 16'd20);
      chk("lat_read0", 64'(avm.master_read), 64'd0);
      chk("lat_busy",  64'(ctrl_busy), 64'd1);
      step(1);
      chk("lat_read1", 64'(avm.master_read), 64'd1);
      chk("lat_addr",  64'(avm.master_address), 64'h39000000);
      chk("lat_burst", 64'(avm.master_burstcount), 64'd8);
      wait_done(300);
      step(4);
      chk("al_nreq", 64'(reqs.size()), 64'd3);
      chk_req("al_b0", 0, 32'h39000000, 8);
      chk_req("al_b1", 1, 32'h39000020, 8);
      chk_req("al_b2", 2, 32'h39000040, 4);
      if (reqs.size() >= 2) chk("al_gap", 64'(reqs[1].cyc - reqs[0].cyc), 64'd2);
      chk("al_pops",  64'(pops), 64'd20);
      chk("al_done",  64'(done_cnt), 64'd1);
      chk("al_dlat",  64'(done_cyc - last_rdv_cyc), 64'd2);
      chk("al_busy",  64'(ctrl_busy), 64'd0);

      // unaligned window split
      clr(); cons_ready = 1;
      start(32'h39000008, 16'd10);
      wait_done(300);
      step(4);
      chk("un_nreq", 64'(reqs.size()), 64'd2);
      chk_req("un_b0", 0, 32'h39000008, 6);
      chk_req("un_b1", 1, 32'h39000020, 4);
      chk("un_pops", 64'(pops), 64'd10);
      chk("un_done", 64'(done_cnt), 64'd1);

      // credit backpressure with a stalled consumer
      clr(); cons_ready = 0;
      start(32'h39001000, 16'd40);
      step(40);
      chk("cr_nreq2", 64'(reqs.size()), 64'd2);
      chk_req("cr_b1", 1, 32'h39001020, 8);
      chk("cr_read_lo", 64'(avm.master_read), 64'd0);
      chk("cr_busy",    64'(ctrl_busy), 64'd1);
      pop_budget = 8; cons_ready = 1;
      step(20);
      chk("cr_pops8", 64'(pops), 64'd8);
      chk("cr_nreq3", 64'(reqs.size()), 64'd3);
      chk_req("cr_b2", 2, 32'h39001040, 8);
      step(20);
      chk("cr_hold3", 64'(reqs.size()), 64'd3);
      pop_budget = -1;
      wait_done(600);
      step(4);
      chk("cr_nreq", 64'(reqs.size()), 64'd5);
      chk("cr_pops", 64'(pops), 64'd40);
      chk("cr_done", 64'(done_cnt), 64'd1);

      // waitrequest held for 5 cycles
      clr(); cons_ready = 1; wait_left = 5;
      start(32'h39002000, 16'd8);
      step(1);
      for (int i = 0; i < 5; i++) begin
         chk("wr_read",  64'(avm.master_read), 64'd1);
         chk("wr_addr",  64'(avm.master_address), 64'h39002000);
         chk("wr_burst", 64'(avm.master_burstcount), 64'd8);
         step(1);
      end
      chk("wr_acc_read", 64'(avm.master_read), 64'd1);
      chk("wr_acc1", 64'(reqs.size()), 64'd1);
      wait_done(300);
      step(4);
      chk("wr_nreq", 64'(reqs.size()), 64'd1);
      chk("wr_pops", 64'(pops), 64'd8);

      // zero length
      clr(); cons_ready = 1;
      start(32'h39003000, 16'd0);
      chk("z_busy1", 64'(ctrl_busy), 64'd1);
      chk("z_done1", 64'(ctrl_done), 64'd0);
      step(1);
      chk("z_done2", 64'(ctrl_done), 64'd1);
      step(1);
      chk("z_done3", 64'(ctrl_done), 64'd0);
      chk("z_busy3", 64'(ctrl_busy), 64'd0);
      step(3);
      chk("z_noread", 64'(saw_read), 64'd0);
      chk("z_ndone",  64'(done_cnt), 64'd1);

      // start while busy is ignored
      clr(); cons_ready = 1;
      start(32'h39003000, 16'd8);
      step(2);
      chk("sb_busy", 64'(ctrl_busy), 64'd1);
      ctrl_baseaddress = 32'h39004000;
      ctrl_length      = 16'd4;
      ctrl_start       = 1'b1;
      step(1);
      ctrl_start       = 1'b0;
      wait_done(300);
      step(10);
      chk("sb_nreq", 64'(reqs.size()), 64'd1);
      chk_req("sb_b0", 0, 32'h39003000, 8);
      chk("sb_pops", 64'(pops), 64'd8);
      chk("sb_done", 64'(done_cnt), 64'd1);
      chk("sb_busy_end", 64'(ctrl_busy), 64'd0);

      // reset after 3 of 8 words returned
      clr(); cons_ready = 0; ret_budget = 3;
      start(32'h39005000, 16'd8);
      step(10);
      chk("mr_rets3",  64'(rets), 64'd3);
      chk("mr_valid",  64'(st_valid), 64'd1);
      chk("mr_busy",   64'(ctrl_busy), 64'd1);
      rst_n = 1'b0;
      for (int i = 0; i < pend.size(); i++) pend[i].stale = 1'b1;
      occ = 0;
      #1;
      chk("mr_rst_read",  64'(avm.master_read), 64'd0);
      chk("mr_rst_addr",  64'(avm.master_address), 64'd0);
      chk("mr_rst_burst", 64'(avm.master_burstcount), 64'd0);
      chk("mr_rst_busy",  64'(ctrl_busy), 64'd0);
      chk("mr_rst_done",  64'(ctrl_done), 64'd0);
      chk("mr_rst_valid", 64'(st_valid), 64'd0);
      chk("mr_rst_data",  64'(st_data), 64'd0);
      chk("mr_rst_be",    64'(avm.master_byteenable), 64'hF);
      step(2);
      rst_n = 1'b1;
      ret_budget = -1; cons_ready = 1;
      step(12);
      chk("mr_stale5", 64'(stale_rets), 64'd5);
      chk("mr_pops0",  64'(pops), 64'd0);
      chk("mr_valid0", 64'(st_valid), 64'd0);
      chk("mr_busy0",  64'(ctrl_busy), 64'd0);
      chk("mr_read0",  64'(avm.master_read), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
